button_press_decoder: RTL and testbench



---
 rtl/button_press_decoder.sv | 117 +++++++++++
 tb/tb_button_press_decoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/button_press_decoder.sv
// Push-button conditioner: two-flop synchronizer, debounce filter and a
// press/hold FSM producing a clean level plus single-cycle event strobes.
module button_press_decoder #(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

    logic          sync_meta;
    logic          btn_sync;
    logic [DW-1:0] db_cnt;
    logic          flip;
    logic          rise;
    logic          fall;
    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;

    // The level flips on the edge where the disagreement count would reach DEBOUNCE_CYCLES.
    assign flip = (btn_sync != btn_level) && (db_cnt == DB_LAST);
    assign rise = flip &&  btn_sync;
    assign fall = flip && !btn_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta     <= 1'b0;
            btn_sync      <= 1'b0;
            btn_level     <= 1'b0;
            db_cnt        <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let btn_sync take the old sync_meta, forming a true two-stage synchronizer.
            sync_meta     <= button;
            btn_sync      <= sync_meta;
            press_pulse   <= rise;
            release_pulse <= fall;
            if (btn_sync == btn_level) begin
                db_cnt <= '0;
            end else if (flip) begin
                btn_level <= btn_sync;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Hold FSM runs off the next debounced level so its strobes align with press/release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            rep_cnt      <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= HELD;
                        hold_cnt <= HW'(1);
                    end
                end
                HELD: begin
                    if (fall) begin
                        state       <= IDLE;
                        short_press <= 1'b1;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state      <= LONG;
                        long_press <= 1'b1;
                        rep_cnt    <= '0;
                        hold_cnt   <= hold_cnt + 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                LONG: begin
                    if (fall) begin
                        state <= IDLE;
                    end else if (rep_cnt == REP_LAST) begin
                        repeat_pulse <= 1'b1;
                        rep_cnt      <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_press_decoder.sv
// Randomized and directed bench for button_press_decoder, checked every cycle
// against a history-window / run-length model of the button behaviour.
module tb_button_press_decoder;

    localparam int DEB   = 4;
    localparam int LONGC = 20;
    localparam int REP   = 8;

    logic clk = 1'b0;
    logic rst;
    logic button;
    logic btn_level, press_pulse, release_pulse, short_press, long_press, repeat_pulse;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model state: recent button samples, debounced level, length of current high run.
    bit hist[DEB+2];
    bit m_level;
    int hold_len;

    int cnt_press, cnt_release, cnt_short, cnt_long, cnt_rep;

    button_press_decoder #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONGC),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .button       (button),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (hist[i]) hist[i] = 1'b0;
        m_level  = 1'b0;
        hold_len = 0;
    endtask

    task automatic clear_counts();
        cnt_press = 0; cnt_release = 0; cnt_short = 0; cnt_long = 0; cnt_rep = 0;
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic step(input bit b, input bit r);
        logic [5:0] exp_v;
        logic [5:0] got_v;
        bit all_diff, nl, e_press, e_rel, e_short, e_long, e_rep;
        button = b;
        rst    = r;
        @(posedge clk);
        cyc++;
        if (r) begin
            model_reset();
            exp_v = '0;
        end else begin
            for (int i = DEB + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = b;
            // Synchronized input lags two samples; level flips once it disagreed for DEB samples.
            all_diff = 1'b1;
            for (int i = 2; i <= DEB + 1; i++) if (hist[i] == m_level) all_diff = 1'b0;
            nl      = all_diff ? !m_level : m_level;
            e_press = nl && !m_level;
            e_rel   = !nl && m_level;
            if (nl) hold_len = m_level ? hold_len + 1 : 1;
            e_long  = nl && (hold_len == LONGC);
            e_rep   = nl && (hold_len > LONGC) && (((hold_len - LONGC) % REP) == 0);
            e_short = e_rel && (hold_len < LONGC);
            if (!nl) hold_len = 0;
            m_level = nl;
            exp_v   = {nl, e_press, e_rel, e_short, e_long, e_rep};
        end
        #1;
        got_v = {btn_level, press_pulse, release_pulse, short_press, long_press, repeat_pulse};
        check($sformatf("outs@%0d", cyc), 32'(got_v), 32'(exp_v));
        cnt_press   += int'(press_pulse);
        cnt_release += int'(release_pulse);
        cnt_short   += int'(short_press);
        cnt_long    += int'(long_press);
        cnt_rep     += int'(repeat_pulse);
    endtask

    task automatic hold(input bit b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0);
    endtask

    initial begin
        model_reset();
        clear_counts();
        button = 1'b0;
        rst    = 1'b1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        hold(1'b0, 4);

        // Clean short press
        clear_counts();
        hold(1'b1, 10);
        hold(1'b0, 15);
        check("clean_press", 32'(cnt_press), 1);
        check("clean_release", 32'(cnt_release), 1);
        check("clean_short", 32'(cnt_short), 1);
        check("clean_long", 32'(cnt_long), 0);

        // Bouncy press
        clear_counts();
        hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 2);
        hold(1'b1, 12);
        check("bounce_press", 32'(cnt_press), 1);
        hold(1'b0, 15);

        // Long hold with repeats
        clear_counts();
        hold(1'b1, 40);
        hold(1'b0, 15);
        check("hold_long", 32'(cnt_long), 1);
        check("hold_repeat", 32'(cnt_rep), 2);
        check("hold_short", 32'(cnt_short), 0);
        check("hold_release", 32'(cnt_release), 1);

        // Release on the cycle the hold would reach LONG
        clear_counts();
        hold(1'b1, LONGC - 1);
        hold(1'b0, 15);
        check("edge_short", 32'(cnt_short), 1);
        check("edge_long", 32'(cnt_long), 0);

        // One cycle longer: long wins
        clear_counts();
        hold(1'b1, LONGC);
        hold(1'b0, 15);
        check("edge2_short", 32'(cnt_short), 0);
        check("edge2_long", 32'(cnt_long), 1);

        // Reset while in LONG with button held, then a fresh press
        hold(1'b1, 30);
        clear_counts();
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
        hold(1'b1, 30);
        check("rst_release", 32'(cnt_release), 0);
        check("rst_press", 32'(cnt_press), 1);
        check("rst_long", 32'(cnt_long), 1);
        hold(1'b0, 15);

        // Short glitch while idle
        clear_counts();
        hold(1'b1, 3);
        hold(1'b0, 12);
        check("glitch_events", 32'(cnt_press + cnt_release + cnt_short + cnt_long + cnt_rep), 0);

        // Random runs, including bounce-length bursts and occasional resets
        for (int k = 0; k < 150; k++) begin
            int len;
            bit b;
            b   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(1, 45);
            if ($urandom_range(0, 39) == 0) begin
                for (int j = 0; j < $urandom_range(1, 3); j++) step(b, 1'b1);
            end
            hold(b, len);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
